// File: rtl/seg_scan_if.sv
// Load/status/display bundle between the reaction-timer control logic and
// the seven-segment scanner. master = timer side, slave = display side.
interface seg_scan_if #(
  parameter int WIDTH = 11
);
  logic             load;
  logic [WIDTH-1:0] value;
  logic [1:0]       mode;
  logic             busy;
  logic [6:0]       codeout;
  logic [7:0]       seg;

  modport master (
    output load, value, mode,
    input  busy, codeout, seg
  );

  modport slave (
    input  load, value, mode,
    output busy, codeout, seg
  );
endinterface

// File: rtl/seg_scan_display.sv
// Binary-to-BCD (double-dabble) converter feeding a 4-digit multiplexed
// seven-segment scanner. Optional macro SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_display #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int WIDTH   = 11           // legal range 4..14
) (
  input  logic      clk,
  input  logic      clr,
  seg_scan_if.slave bus
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int PW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CW    = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_BLANK = 2'b00,
    MODE_NUM   = 2'b01,
    MODE_DASH  = 2'b10,
    MODE_LAMP  = 2'b11
  } mode_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh;
  logic [15:0]      acc, acc_adj;
  logic             ovf;
  logic [CW-1:0]    cnt;
  mode_t            mode_ld, mode_q, mode_nxt;
  logic [3:0]       dig     [4];
  logic [3:0]       dig_nxt [4];

  logic [PW-1:0]    presc;
  logic [1:0]       idx, idx_nxt;
  logic             tc;
  logic             lz;
  logic [6:0]       code_nxt, codeout_q;
  logic [7:0]       seg_nxt, seg_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = 7'h00;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.load) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == SHIFT) || (state == DONE);
  end

  // ----------------------------------------------------------- datapath
  // Add-3 correction on each BCD nibble ahead of the shift.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sh      <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
      mode_ld <= MODE_BLANK;
    end else begin
      unique case (state)
        IDLE: if (bus.load) begin
          sh      <= bus.value;
          acc     <= '0;
          ovf     <= 1'b0;
          cnt     <= CW'(WIDTH);
          mode_ld <= mode_t'(bus.mode);
        end
        SHIFT: begin
          // A bit leaving the thousands nibble is a carry into a fifth
          // digit, i.e. the value exceeds 9999; keep it sticky.
          acc <= {acc_adj[14:0], sh[WIDTH-1]};
          ovf <= ovf | acc_adj[15];
          sh  <= {sh[WIDTH-2:0], 1'b0};
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Display register and mode take effect together on the DONE edge.
  always_comb begin
    mode_nxt = mode_q;
    for (int i = 0; i < 4; i++) dig_nxt[i] = dig[i];
    if (state == DONE) begin
      mode_nxt = mode_ld;
      for (int i = 0; i < 4; i++) dig_nxt[i] = ovf ? 4'd9 : acc[4*i +: 4];
    end
  end

  // ------------------------------------------------------------ scanner
  assign tc      = (presc == PW'(DWELL - 1));
  assign idx_nxt = tc ? idx + 2'd1 : idx;

  always_comb begin
    lz = 1'b0;
`ifdef SEG_SCAN_LZB_EN
    lz = (idx_nxt != 2'd0);
    for (int j = 0; j < 4; j++) begin
      if (j >= int'(idx_nxt) && dig_nxt[j] != 4'd0) lz = 1'b0;
    end
`endif
  end

  // Encode from next-state values so codeout and seg share one register
  // stage and switch on the same edge.
  always_comb begin
    seg_nxt  = {4'hF, ~(4'b0001 << idx_nxt)};
    code_nxt = 7'h00;
    unique case (mode_nxt)
      MODE_BLANK: code_nxt = 7'h00;
      MODE_NUM:   code_nxt = lz ? 7'h00 : seg7(dig_nxt[idx_nxt]);
      MODE_DASH:  code_nxt = 7'h40;
      MODE_LAMP:  code_nxt = 7'h7F;
      default:    code_nxt = 7'h00;
    endcase
  end

  // NOTE: the 4-entry display register is reset like any other flop; it is
  // tiny and must read 0 out of reset, unlike a RAM that would be left unreset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      presc     <= '0;
      idx       <= '0;
      mode_q    <= MODE_BLANK;
      for (int i = 0; i < 4; i++) dig[i] <= '0;
      seg_q     <= 8'hFF;
      codeout_q <= 7'h00;
    end else begin
      presc     <= tc ? '0 : presc + PW'(1);
      idx       <= idx_nxt;
      mode_q    <= mode_nxt;
      for (int i = 0; i < 4; i++) dig[i] <= dig_nxt[i];
      seg_q     <= seg_nxt;
      codeout_q <= code_nxt;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.codeout = codeout_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (CLK_HZ=8, SCAN_HZ=2 -> 4 cycles/digit, WIDTH=11).
// Expectations follow SEG_SCAN_LZB_EN when the macro is defined for the build.
module tb_seg_scan_display;

  localparam int WIDTH = 11;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   n;

  seg_scan_if #(.WIDTH(WIDTH)) bus ();

  seg_scan_display #(
    .CLK_HZ (8),
    .SCAN_HZ(2),
    .WIDTH  (WIDTH)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef SEG_SCAN_LZB_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_seg(input logic [7:0] s, input string tag);
    int k = 0;
    while (bus.seg !== s && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " seg"}, {8'h00, bus.seg}, {8'h00, s});
  endtask

  task automatic show4(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                       input logic [6:0] e2, input logic [6:0] e3);
    wait_seg(8'hFE, tag); check({tag, " d0"}, {9'h0, bus.codeout}, {9'h0, e0});
    wait_seg(8'hFD, tag); check({tag, " d1"}, {9'h0, bus.codeout}, {9'h0, e1});
    wait_seg(8'hFB, tag); check({tag, " d2"}, {9'h0, bus.codeout}, {9'h0, e2});
    wait_seg(8'hF7, tag); check({tag, " d3"}, {9'h0, bus.codeout}, {9'h0, e3});
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v, input logic [1:0] m);
    @(negedge clk);
    bus.load  = 1'b1;
    bus.value = v;
    bus.mode  = m;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  // Continue counting busy-high negedge samples until busy drops (bounded).
  task automatic finish_busy(input int start, output int cnt);
    cnt = start;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
      else break;
    end
  endtask

  initial begin
    bus.load  = 1'b0;
    bus.value = '0;
    bus.mode  = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset codeout", {9'h0, bus.codeout}, 16'h0000);
    check("reset seg",     {8'h0, bus.seg},     16'h00FF);
    check("reset busy",    {15'h0, bus.busy},   16'h0000);

    // Release: first edge selects digit 0, then 4-cycle dwell per digit
    clr = 1'b1;
    @(posedge clk); #1;
    check("first seg", {8'h0, bus.seg}, 16'h00FE);
    wait_seg(8'hFD, "scan");
    n = 0;
    while (bus.seg === 8'hFD && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("dwell cycles", 16'(n), 16'd4);
    check("scan order", {8'h0, bus.seg}, 16'h00FB);
    wait_seg(8'hF7, "scan3");
    wait_seg(8'hFE, "scan wrap");

    // Numeric 1234
    do_load(11'd1234, 2'b01);
    check("busy after load", {15'h0, bus.busy}, 16'h0001);
    finish_busy(1, n);
    check("busy len 1234", 16'(n), 16'd12);
    show4("1234", 7'h66, 7'h4F, 7'h5B, 7'h06);

    // Value 7 (leading zeros)
    do_load(11'd7, 2'b01);
    finish_busy(1, n);
    show4("0007", 7'h07, LZ, LZ, LZ);

    // Value 0: ones digit never blanked
    do_load(11'd0, 2'b01);
    finish_busy(1, n);
    show4("0000", 7'h3F, LZ, LZ, LZ);

    // 2047, then a second load two cycles later while busy -> ignored
    do_load(11'd2047, 2'b01);
    n = bus.busy ? 1 : 0;
    @(negedge clk);
    if (bus.busy) n++;
    bus.load  = 1'b1;
    bus.value = 11'd5;
    bus.mode  = 2'b10;
    @(negedge clk);
    if (bus.busy) n++;
    bus.load  = 1'b0;
    finish_busy(n, n);
    check("busy len 2047", 16'(n), 16'd12);
    show4("2047", 7'h07, 7'h66, 7'h3F, 7'h5B);

    // Non-numeric modes
    do_load(11'd123, 2'b10);
    finish_busy(1, n);
    show4("dash", 7'h40, 7'h40, 7'h40, 7'h40);
    do_load(11'd123, 2'b11);
    finish_busy(1, n);
    show4("lamp", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    do_load(11'd123, 2'b00);
    finish_busy(1, n);
    show4("blank", 7'h00, 7'h00, 7'h00, 7'h00);

    // Reset mid-conversion, then a normal load
    do_load(11'd1500, 2'b01);
    repeat (4) @(negedge clk);
    clr = 1'b0;
    #1;
    check("abort codeout", {9'h0, bus.codeout}, 16'h0000);
    check("abort seg",     {8'h0, bus.seg},     16'h00FF);
    check("abort busy",    {15'h0, bus.busy},   16'h0000);
    @(negedge clk);
    clr = 1'b1;
    do_load(11'd999, 2'b01);
    finish_busy(1, n);
    check("busy len 0999", 16'(n), 16'd12);
    show4("0999", 7'h6F, 7'h6F, 7'h6F, LZ);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
